// File: rtl/dm_stack_seq.sv
// dm_stack_seq: 16-bit stack pointer plus PUSH/POP/CALL/RET sequencer that
// moves one byte per cycle over the shared data-memory port.
// Optional build macro: DM_STACK_OVF_EN enables the sticky stack-overflow
// comparator against STACK_LIMIT. When it is undefined, sp_ovf is tied low.
module dm_stack_seq #(
    parameter int unsigned SP_WIDTH    = 16,
    parameter logic [15:0] SP_INIT     = 16'h045F,
    parameter logic [15:0] STACK_LIMIT = 16'h0060
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_we,
    input  logic        sp_l_en,
    input  logic        sp_h_en,
    input  logic [7:0]  io_wdata,
    output logic [7:0]  io_rdata,
    input  logic        cmd_push,
    input  logic        cmd_pop,
    input  logic        cmd_call,
    input  logic        cmd_ret,
    input  logic [7:0]  push_data,
    input  logic [15:0] pc_in,
    output logic        busy,
    output logic [15:0] dm_addr,
    output logic [7:0]  dm_wdata,
    output logic        dm_we,
    output logic        dm_re,
    input  logic [7:0]  dm_rdata,
    output logic [7:0]  pop_data,
    output logic        pop_valid,
    output logic [15:0] pc_out,
    output logic        pc_valid,
    output logic        sp_ovf
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_B = 3'd2,
        S_RD_A = 3'd3,
        S_RD_B = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    state_e                state_q;
    op_e                   op_q;
    logic [SP_WIDTH-1:0]   sp_q;
    logic [AW-1:0]         wdata_q;
    logic [DW-1:0]         pc_hi_q;
    logic                  busy_q;
    logic                  dm_we_q;
    logic                  dm_re_q;
    logic [AW-1:0]         dm_addr_q;
    logic [DW-1:0]         dm_wdata_q;
    logic                  pop_valid_q;
    logic                  pc_valid_q;
    logic                  sp_ovf_q;

    logic [SP_WIDTH-1:0]   sp_inc;
    logic [SP_WIDTH-1:0]   sp_inc2;
    logic [SP_WIDTH-1:0]   sp_dec;
    logic [AW-1:0]         sp16;
    logic [AW-1:0]         sp_io16;
    logic                  io_sp_wr;

    // SP neighbours (modulo 2^SP_WIDTH) and the value an I/O write would produce
    always_comb begin
        sp_inc   = sp_q + SP_WIDTH'(1);
        sp_inc2  = sp_q + SP_WIDTH'(2);
        sp_dec   = sp_q - SP_WIDTH'(1);
        sp16     = AW'(sp_q);
        sp_io16  = sp16;
        io_sp_wr = io_we && (sp_l_en || sp_h_en);
        if (io_we && sp_l_en) begin
            sp_io16[7:0] = io_wdata;
        end
        if (io_we && sp_h_en) begin
            sp_io16[15:8] = io_wdata;
        end
    end

    // Sequencer FSM: state, SP and registered memory-port strobes for the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_PUSH;
            sp_q        <= SP_WIDTH'(SP_INIT);
            wdata_q     <= '0;
            pc_hi_q     <= '0;
            busy_q      <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_re_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            pop_valid_q <= 1'b0;
            pc_valid_q  <= 1'b0;
        end else begin
            dm_we_q     <= 1'b0;
            dm_re_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            pop_valid_q <= 1'b0;
            pc_valid_q  <= 1'b0;
            busy_q      <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (cmd_call) begin
                        op_q       <= OP_CALL;
                        wdata_q    <= pc_in;
                        state_q    <= S_WR_A;
                        dm_we_q    <= 1'b1;
                        dm_addr_q  <= sp16;
                        dm_wdata_q <= pc_in[7:0];
                    end else if (cmd_ret) begin
                        op_q      <= OP_RET;
                        state_q   <= S_RD_A;
                        dm_re_q   <= 1'b1;
                        dm_addr_q <= AW'(sp_inc);
                    end else if (cmd_push) begin
                        op_q       <= OP_PUSH;
                        wdata_q    <= {8'h00, push_data};
                        state_q    <= S_WR_A;
                        dm_we_q    <= 1'b1;
                        dm_addr_q  <= sp16;
                        dm_wdata_q <= push_data;
                    end else if (cmd_pop) begin
                        op_q      <= OP_POP;
                        state_q   <= S_RD_A;
                        dm_re_q   <= 1'b1;
                        dm_addr_q <= AW'(sp_inc);
                    end else begin
                        busy_q <= 1'b0;
                        if (io_sp_wr) begin
                            sp_q <= SP_WIDTH'(sp_io16);
                        end
                    end
                end
                S_WR_A: begin
                    sp_q <= sp_dec;
                    if (op_q == OP_CALL) begin
                        state_q    <= S_WR_B;
                        dm_we_q    <= 1'b1;
                        dm_addr_q  <= AW'(sp_dec);
                        dm_wdata_q <= wdata_q[15:8];
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_WR_B: begin
                    sp_q    <= sp_dec;
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_RD_A: begin
                    sp_q <= sp_inc;
                    if (op_q == OP_RET) begin
                        state_q   <= S_RD_B;
                        dm_re_q   <= 1'b1;
                        dm_addr_q <= AW'(sp_inc2);
                    end else begin
                        state_q     <= S_FIN;
                        pop_valid_q <= 1'b1;
                    end
                end
                S_RD_B: begin
                    sp_q       <= sp_inc;
                    pc_hi_q    <= dm_rdata;
                    state_q    <= S_FIN;
                    pc_valid_q <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DM_STACK_OVF_EN
    // Sticky overflow: any write cycle below the stack limit sets it until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_ovf_q <= 1'b0;
        end else if (dm_we_q && (dm_addr_q < STACK_LIMIT)) begin
            sp_ovf_q <= 1'b1;
        end
    end
`else
    logic unused_stack_limit;
    assign unused_stack_limit = ^STACK_LIMIT;
    assign sp_ovf_q = 1'b0;
`endif

    // Read data only exists in FIN, so result bytes come straight off dm_rdata
    assign pop_data  = pop_valid_q ? dm_rdata : 8'h00;
    assign pc_out    = pc_valid_q ? {pc_hi_q, dm_rdata} : 16'h0000;
    assign io_rdata  = sp_l_en ? sp16[7:0] : (sp_h_en ? sp16[15:8] : 8'h00);

    assign busy      = busy_q;
    assign dm_we     = dm_we_q;
    assign dm_re     = dm_re_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign pop_valid = pop_valid_q;
    assign pc_valid  = pc_valid_q;
    assign sp_ovf    = sp_ovf_q;

endmodule

// File: doc/dm_stack_seq.md
# dm_stack_seq

Stack-pointer register and stack access sequencer for the data-memory side of the CPU. It owns the 16-bit SP. It serves the SP low/high I/O enables produced by the I/O enable decode. It sequences single-byte PUSH/POP and two-byte CALL/RET (PC save/restore) onto the shared data-memory port, one byte per cycle, with a busy handshake to the core control.

## Interface
Parameters:
- SP_WIDTH, 16, implemented SP bits (9..16); unused high bits read 0.
- SP_INIT, 16'h045F, SP value after reset.
- STACK_LIMIT, 16'h0060, lowest legal push address; used only with DM_STACK_OVF_EN.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_we  in  1  I/O write strobe.
- sp_l_en  in  1  SP low byte selected (I/O 0x3D).
- sp_h_en  in  1  SP high byte selected (I/O 0x3E).
- io_wdata  in  8  I/O write data.
- io_rdata  out  8  SP byte read-back; combinational.
- cmd_push  in  1  push push_data.
- cmd_pop  in  1  pop one byte.
- cmd_call  in  1  push pc_in (low byte first).
- cmd_ret  in  1  pop PC (high byte first).
- push_data  in  8  byte for cmd_push.
- pc_in  in  16  return address for cmd_call.
- busy  out  1  sequence in progress; commands ignored.
- dm_addr  out  16  data-memory address.
- dm_wdata  out  8  data-memory write data.
- dm_we  out  1  data-memory write strobe.
- dm_re  out  1  data-memory read strobe; dm_rdata is valid the next cycle.
- dm_rdata  in  8  data-memory read data.
- pop_data  out  8  popped byte, valid while pop_valid.
- pop_valid  out  1  one-cycle pop result strobe.
- pc_out  out  16  restored PC, valid while pc_valid.
- pc_valid  out  1  one-cycle RET result strobe.
- sp_ovf  out  1  sticky stack-overflow flag.

## Operation
- States: IDLE, WR_A, WR_B, RD_A, RD_B, FIN.
- IDLE:
  - busy=0; a command is accepted when any cmd_* is high.
  - Priority is call > ret > push > pop; lower-priority commands in the same cycle are dropped.
  - push_data and pc_in are latched at accept.
- WR_A:
  - dm_we=1, dm_addr=SP, dm_wdata = push_data or pc_in[7:0]; SP<=SP-1.
  - Next state: push -> IDLE; call -> WR_B.
- WR_B (call only): dm_we=1, dm_addr=SP, dm_wdata=pc_in[15:8]; SP<=SP-1; next IDLE.
- RD_A:
  - dm_re=1, dm_addr=SP+1; SP<=SP+1.
  - Next state: pop -> FIN; ret -> RD_B.
- RD_B (ret only): latch dm_rdata as PC high; dm_re=1, dm_addr=SP+1; SP<=SP+1; next FIN.
- FIN:
  - pop: pop_valid=1, pop_data=dm_rdata.
  - ret: pc_valid=1, pc_out={latched high, dm_rdata}.
  - Next state: IDLE.
- busy=1 in every non-IDLE state.
- SP I/O:
  - When io_we && sp_l_en, SP[7:0]<=io_wdata; when io_we && sp_h_en, SP[15:8]<=io_wdata (truncated to SP_WIDTH). Both writes apply if both enables are high.
  - An I/O write to SP is honoured only in IDLE with no command accepted that cycle. Otherwise it is discarded.
- io_rdata = sp_l_en ? SP[7:0] : sp_h_en ? SP[15:8] : 8'h00.
- Arithmetic: SP and SP+1 are computed modulo 2^SP_WIDTH. 0 decrements to 2^SP_WIDTH-1, and the maximum value increments to 0. No saturation.
- Outputs are 0 whenever they are not driven by the current state (dm_*, pop_*, pc_*).

## Timing
- Reset (async, rst_n low): state=IDLE, SP=SP_INIT, busy=0, dm_we=dm_re=0, dm_addr=0, dm_wdata=0, pop_valid=pc_valid=0, pop_data=0, pc_out=0, sp_ovf=0.
- Reset mid-sequence aborts the sequence immediately. Partial SP updates are lost and SP returns to SP_INIT.
- Command accepted at edge N:
  - push: dm_we in cycle N+1.
  - call: dm_we in N+1 and N+2.
  - pop: dm_re in N+1, pop_valid in N+2.
  - ret: dm_re in N+1 and N+2, pc_valid in N+3.
- busy duration: push 1, call 2, pop 2, ret 3 cycles. A new command may be accepted in the first cycle busy is low.
- io_rdata is combinational and reflects SP as of the current cycle, including mid-sequence values.

## Configuration
- DM_STACK_OVF_EN defined: sp_ovf is set on any dm_we cycle with dm_addr < STACK_LIMIT. It stays set until reset. The write still occurs.
- DM_STACK_OVF_EN undefined: no comparator is built and sp_ovf is tied to 0.

## Test plan
- Reset, then drive sp_l_en to read back -> io_rdata=8'h5F; with sp_h_en -> 8'h04; busy=0.
- I/O write SP=16'h0100, cmd_push with push_data=8'hA5 -> one dm_we cycle with addr 16'h0100, data 8'hA5; SP=16'h00FF after.
- cmd_call with pc_in=16'h1234 at SP=16'h0100, then cmd_ret -> writes 34@0100 and 12@00FF; ret reads 00FF then 0100; pc_out=16'h1234 with pc_valid for 1 cycle; SP=16'h0100.
- cmd_push and cmd_pop in the same cycle; separately, an SP I/O write during busy -> only the push executes; the I/O write is dropped and SP is unchanged by it.
- SP=16'h0000, cmd_push -> write at 16'h0000, SP=16'hFFFF; with DM_STACK_OVF_EN, sp_ovf=1 and stays 1.
- rst_n low in RD_B of a ret -> busy=0, pc_valid never asserted, SP=SP_INIT.
